// File: rtl/xnor_lane_pipe.sv
// rtl/xnor_lane_pipe.sv - registered XOR/XNOR unit with running-XOR accumulator and 2-entry output buffer
//
// Purpose:
//   Computes a^b, ~(a^b), acc^a^b (updating acc) or loads acc with a, one beat
//   per cycle. Results are held in an output register backed by a skid register,
//   so the upstream ready never depends on the downstream ready. Each result
//   carries a per-lane parity vector computed before registering.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous reset, active-high
//   in_valid   input beat valid
//   in_ready   unit can accept a beat (registered state only)
//   mode       00 XOR, 01 XNOR, 10 ACC_XOR, 11 ACC_LOAD
//   a, b       operands
//   out_valid  result valid
//   out_ready  downstream accepts result
//   out_data   result
//   out_parity XOR-reduce of each LANE_W-bit lane of out_data
//   acc_value  current accumulator contents

module xnor_lane_pipe #(
    parameter int WIDTH  = 64,
    parameter int LANE_W = 16,
    localparam int LANES = WIDTH / LANE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [LANES-1:0] out_parity,
    output logic [WIDTH-1:0] acc_value
);

    localparam logic [1:0] MODE_XOR      = 2'b00;
    localparam logic [1:0] MODE_XNOR     = 2'b01;
    localparam logic [1:0] MODE_ACC_XOR  = 2'b10;
    localparam logic [1:0] MODE_ACC_LOAD = 2'b11;

    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [LANES-1:0] out_parity_q;
    logic             skid_valid_q;
    logic [WIDTH-1:0] skid_data_q;
    logic [LANES-1:0] skid_parity_q;
    logic [WIDTH-1:0] acc_q;

    logic             accept;
    logic             pop;
    logic             acc_update;
    logic [WIDTH-1:0] result;
    logic [LANES-1:0] result_parity;

    function automatic logic [LANES-1:0] lane_parity(input logic [WIDTH-1:0] d);
        logic [LANES-1:0] p;
        p = '0;
        for (int i = 0; i < LANES; i++) begin
            p[i] = ^d[i*LANE_W +: LANE_W];
        end
        return p;
    endfunction

    // Ready is a function of the skid flag only: as long as the skid entry is
    // free, a beat arriving while the output register is stalled still has a home.
    assign in_ready = ~rst & ~skid_valid_q;
    assign accept   = in_valid & in_ready;
    assign pop      = out_valid_q & out_ready;

    always_comb begin
        result     = '0;
        acc_update = 1'b0;
        unique case (mode)
            MODE_XOR:      result = a ^ b;
            MODE_XNOR:     result = ~(a ^ b);
            MODE_ACC_XOR: begin
                result     = acc_q ^ a ^ b;
                acc_update = 1'b1;
            end
            MODE_ACC_LOAD: begin
                result     = a;
                acc_update = 1'b1;
            end
            default: begin
                result     = '0;
                acc_update = 1'b0;
            end
        endcase
        result_parity = lane_parity(result);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_parity_q  <= '0;
            skid_valid_q  <= 1'b0;
            skid_data_q   <= '0;
            skid_parity_q <= '0;
            acc_q         <= '0;
        end else begin
            if (accept && acc_update) begin
                acc_q <= result;
            end

            if (pop) begin
                if (skid_valid_q) begin
                    // Skid full implies in_ready=0, so no new beat competes here.
                    out_data_q   <= skid_data_q;
                    out_parity_q <= skid_parity_q;
                    skid_valid_q <= 1'b0;
                end else if (accept) begin
                    // Head leaves and new beat replaces it in the same cycle.
                    out_data_q   <= result;
                    out_parity_q <= result_parity;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end else if (accept) begin
                if (!out_valid_q) begin
                    out_valid_q  <= 1'b1;
                    out_data_q   <= result;
                    out_parity_q <= result_parity;
                end else begin
                    skid_valid_q  <= 1'b1;
                    skid_data_q   <= result;
                    skid_parity_q <= result_parity;
                end
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_parity = out_parity_q;
    assign acc_value  = acc_q;

endmodule
